// File: rtl/mm_tile_controller_pkg.sv
// Shared types and helpers for the tiled matrix-multiply sequencer:
// FSM encodings, tile arithmetic and row-mask generation.
package mm_tile_controller_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } main_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT,
      W_BUSY,
      W_DONE
   } wr_state_e;

   // Exact ceiling division; avoids the a+d-1 overflow at the top of range.
   function automatic logic [31:0] ceil_div(input logic [31:0] a,
                                            input logic [31:0] d);
      logic [31:0] q;
      q = a / d;
      if ((a % d) != 32'd0) q = q + 32'd1;
      return q;
   endfunction

   // Tile edge for batch idx of nb: full DIM except a ragged last tile.
   function automatic logic [31:0] tile_size(input logic [31:0] total,
                                             input logic [31:0] idx,
                                             input logic [31:0] nb,
                                             input logic [31:0] dim);
      logic [31:0] r;
      r = total % dim;
      if ((idx == nb - 32'd1) && (r != 32'd0)) return r;
      return dim;
   endfunction

   // Low n bits set.
   function automatic logic [31:0] dim_mask(input logic [31:0] n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (32'(i) < n) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mm_tile_controller_wr_sequencer.sv
// Write-back sequencer: waits out array latency, then streams one tile
// column per cycle into buffer P.
// Ports: clk_i/rst_ni, abort_i, load_i (latch base_p_i), pe_we_i with
// bm_i/bn_i tile sizes, enp_o/wep_o/addrp_o/data_en_o, idle_o/done_o.
module mm_wr_sequencer
   import mm_tile_controller_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DIM        = 8,
   parameter int OUTPUT_LAT = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  abort_i,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] base_p_i,
   input  logic                  pe_we_i,
   input  logic [ADDR_WIDTH-1:0] bm_i,
   input  logic [ADDR_WIDTH-1:0] bn_i,
   output logic                  enp_o,
   output logic                  wep_o,
   output logic [ADDR_WIDTH-1:0] addrp_o,
   output logic [DIM-1:0]        data_en_o,
   output logic                  idle_o,
   output logic                  done_o
);

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] LAT = ADDR_WIDTH'(OUTPUT_LAT);

   wr_state_e             w_state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [ADDR_WIDTH-1:0] bm_q;
   logic [ADDR_WIDTH-1:0] bn_q;
   logic [ADDR_WIDTH-1:0] addrp_q;
   logic                  enp_q;
   logic [DIM-1:0]        data_en_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_state_q <= W_IDLE;
         cnt_q     <= '0;
         bm_q      <= '0;
         bn_q      <= '0;
         addrp_q   <= '0;
         enp_q     <= 1'b0;
         data_en_q <= '0;
      end else if (abort_i) begin
         w_state_q <= W_IDLE;
         cnt_q     <= '0;
         bm_q      <= '0;
         bn_q      <= '0;
         addrp_q   <= '0;
         enp_q     <= 1'b0;
         data_en_q <= '0;
      end else begin
         if (load_i) addrp_q <= base_p_i;
         unique case (w_state_q)
            W_IDLE: begin
               if (pe_we_i) begin
                  bm_q      <= bm_i;
                  bn_q      <= bn_i;
                  cnt_q     <= LAT + bm_i - ONE;
                  w_state_q <= W_WAIT;
               end
            end
            W_WAIT: begin
               if (cnt_q == '0) begin
                  cnt_q     <= bn_q - ONE;
                  enp_q     <= 1'b1;
                  data_en_q <= DIM'(dim_mask(32'(bm_q)));
                  w_state_q <= W_BUSY;
               end else begin
                  cnt_q <= cnt_q - ONE;
               end
            end
            W_BUSY: begin
               // P address is linear across the whole job.
               addrp_q <= addrp_q + ONE;
               if (cnt_q == '0) begin
                  enp_q     <= 1'b0;
                  data_en_q <= '0;
                  w_state_q <= W_DONE;
               end else begin
                  cnt_q <= cnt_q - ONE;
               end
            end
            W_DONE: w_state_q <= W_IDLE;
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   assign enp_o     = enp_q;
   assign wep_o     = enp_q;
   assign addrp_o   = addrp_q;
   assign data_en_o = data_en_q;
   assign idle_o    = (w_state_q == W_IDLE);
   assign done_o    = (w_state_q == W_DONE);

endmodule

// File: rtl/mm_tile_controller.sv
// Sequencer for an output-stationary DIM x DIM systolic matmul array.
// Ports: clk_i/rst_ni, start_i/abort_i/stall_i, m/k/n and A/B/P bases in;
// valid/err/busy status, PE and systolic strobes, A/B/P buffer ports out.
module mm_tile_controller
   import mm_tile_controller_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DIM        = 8,
   parameter int OUTPUT_LAT = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic                  stall_i,
   input  logic [ADDR_WIDTH-1:0] m_i,
   input  logic [ADDR_WIDTH-1:0] k_i,
   input  logic [ADDR_WIDTH-1:0] n_i,
   input  logic [ADDR_WIDTH-1:0] base_addra_i,
   input  logic [ADDR_WIDTH-1:0] base_addrb_i,
   input  logic [ADDR_WIDTH-1:0] base_addrp_i,
   output logic                  valid_o,
   output logic                  err_o,
   output logic                  busy_o,
   output logic                  pe_clr_o,
   output logic                  pe_we_o,
   output logic                  ensys_o,
   output logic                  bubble_o,
   output logic                  ena_o,
   output logic [ADDR_WIDTH-1:0] addra_o,
   output logic                  enb_o,
   output logic [ADDR_WIDTH-1:0] addrb_o,
   output logic                  enp_o,
   output logic                  wep_o,
   output logic [ADDR_WIDTH-1:0] addrp_o,
   output logic [DIM-1:0]        data_en_o
);

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
   // Batch length floor so one batch's write-back ends before the next.
   localparam logic [ADDR_WIDTH-1:0] MIN_BC =
      ADDR_WIDTH'(OUTPUT_LAT + 2 * DIM + 2);

   main_state_e           state_q;
   logic                  err_q;
   logic [ADDR_WIDTH-1:0] m_q, k_q, n_q, ba_q, bb_q;
   logic [ADDR_WIDTH-1:0] rb_q, cb_q, bc_q;
   logic [ADDR_WIDTH-1:0] cyc_q, col_q, row_q;
   logic [ADDR_WIDTH-1:0] aoff_q, boff_q;
   logic                  rd_done_q;
   logic                  ena_q, clr_q, we_q, bub_q;
   logic [ADDR_WIDTH-1:0] addra_q, addrb_q;
   logic [ADDR_WIDTH-1:0] bm_q, bn_q;

   logic                  dims_ok;
   logic                  load;
   logic                  rd_en;
   logic                  fin;
   logic                  w_idle, w_done;
   logic [ADDR_WIDTH-1:0] bm_d, bn_d;

   assign dims_ok = (m_i != '0) && (k_i != '0) && (n_i != '0);
   assign load    = (state_q == IDLE) && start_i && dims_ok && !abort_i;
   assign rd_en   = (state_q == BUSY) && !rd_done_q &&
                    !((cyc_q == '0) && stall_i);
   // pe_we_q guards the case where the last pe_we and rd_done coincide.
   assign fin     = rd_done_q && !we_q && (w_idle || w_done);

   assign bm_d = ADDR_WIDTH'(tile_size(32'(m_q), 32'(row_q),
                                       32'(rb_q), DIM));
   assign bn_d = ADDR_WIDTH'(tile_size(32'(n_q), 32'(col_q),
                                       32'(cb_q), DIM));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         err_q     <= 1'b0;
         m_q       <= '0;
         k_q       <= '0;
         n_q       <= '0;
         ba_q      <= '0;
         bb_q      <= '0;
         rb_q      <= '0;
         cb_q      <= '0;
         bc_q      <= '0;
         cyc_q     <= '0;
         col_q     <= '0;
         row_q     <= '0;
         aoff_q    <= '0;
         boff_q    <= '0;
         rd_done_q <= 1'b0;
         ena_q     <= 1'b0;
         clr_q     <= 1'b0;
         we_q      <= 1'b0;
         bub_q     <= 1'b0;
         addra_q   <= '0;
         addrb_q   <= '0;
         bm_q      <= '0;
         bn_q      <= '0;
      end else if (abort_i) begin
         state_q   <= IDLE;
         err_q     <= 1'b0;
         cyc_q     <= '0;
         col_q     <= '0;
         row_q     <= '0;
         aoff_q    <= '0;
         boff_q    <= '0;
         rd_done_q <= 1'b0;
         ena_q     <= 1'b0;
         clr_q     <= 1'b0;
         we_q      <= 1'b0;
         bub_q     <= 1'b0;
         addra_q   <= '0;
         addrb_q   <= '0;
         bm_q      <= '0;
         bn_q      <= '0;
      end else begin
         // Read-side strobes are registered together with the address.
         ena_q   <= rd_en;
         clr_q   <= rd_en && (cyc_q == '0);
         we_q    <= rd_en && (cyc_q == k_q - ONE);
         bub_q   <= rd_en && (cyc_q >= k_q);
         addra_q <= ba_q + aoff_q + cyc_q;
         addrb_q <= bb_q + boff_q + cyc_q;
         bm_q    <= bm_d;
         bn_q    <= bn_d;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  m_q       <= m_i;
                  k_q       <= k_i;
                  n_q       <= n_i;
                  ba_q      <= base_addra_i;
                  bb_q      <= base_addrb_i;
                  rb_q      <= ADDR_WIDTH'(ceil_div(32'(m_i), DIM));
                  cb_q      <= ADDR_WIDTH'(ceil_div(32'(n_i), DIM));
                  bc_q      <= (k_i > MIN_BC) ? k_i : MIN_BC;
                  cyc_q     <= '0;
                  col_q     <= '0;
                  row_q     <= '0;
                  aoff_q    <= '0;
                  boff_q    <= '0;
                  rd_done_q <= 1'b0;
                  if (dims_ok) begin
                     state_q <= BUSY;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            BUSY: begin
               if (rd_en) begin
                  if (cyc_q == bc_q - ONE) begin
                     cyc_q <= '0;
                     if (col_q == cb_q - ONE) begin
                        col_q  <= '0;
                        boff_q <= '0;
                        if (row_q == rb_q - ONE) begin
                           rd_done_q <= 1'b1;
                        end else begin
                           row_q  <= row_q + ONE;
                           aoff_q <= aoff_q + k_q;
                        end
                     end else begin
                        col_q  <= col_q + ONE;
                        boff_q <= boff_q + k_q;
                     end
                  end else begin
                     cyc_q <= cyc_q + ONE;
                  end
               end
               if (fin) state_q <= DONE;
            end
            DONE: begin
               if (!start_i) begin
                  err_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   mm_wr_sequencer #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DIM        (DIM),
      .OUTPUT_LAT (OUTPUT_LAT)
   ) u_wr (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .abort_i   (abort_i),
      .load_i    (load),
      .base_p_i  (base_addrp_i),
      .pe_we_i   (we_q),
      .bm_i      (bm_q),
      .bn_i      (bn_q),
      .enp_o     (enp_o),
      .wep_o     (wep_o),
      .addrp_o   (addrp_o),
      .data_en_o (data_en_o),
      .idle_o    (w_idle),
      .done_o    (w_done)
   );

   assign valid_o  = (state_q == DONE);
   assign err_o    = err_q;
   assign busy_o   = (state_q == BUSY);
   assign pe_clr_o = clr_q;
   assign pe_we_o  = we_q;
   assign ensys_o  = ena_q;
   assign bubble_o = bub_q;
   assign ena_o    = ena_q;
   assign enb_o    = ena_q;
   assign addra_o  = addra_q;
   assign addrb_o  = addrb_q;

endmodule
